// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus types: access sequencer states, master-index sizing and the
// default bus widths seen by the CPU memory controller and the debugger.
package nes_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_e;

    localparam int MAX_MASTERS  = 8;
    localparam int MASTER_IDX_W = $clog2(MAX_MASTERS);

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 8;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner select: lowest index wins, searching upward from ptr_i
// (wrapping) when ROTATE is set, otherwise from index 0. Zero latency.
module bus_arb_pick
    import nes_bus_pkg::*;
#(
    parameter int N      = 2,
    parameter bit ROTATE = 1'b0
) (
    input  logic [N-1:0]            req_i,
    input  logic [MASTER_IDX_W-1:0] ptr_i,
    output logic [N-1:0]            grant_o,
    output logic [MASTER_IDX_W-1:0] idx_o
);

    logic [MASTER_IDX_W-1:0] start;
    logic [2*N-1:0]          dbl;
    logic [N-1:0]            rot;
    logic [MASTER_IDX_W:0]   pos;
    logic                    found;

    always_comb begin
        start = ROTATE ? ptr_i : '0;
        // Doubling the vector turns the wrap-around search into a plain shift.
        dbl   = {req_i, req_i} >> start;
        rot   = dbl[N-1:0];
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = (MASTER_IDX_W+1)'(k) + {1'b0, start};
                if (pos >= (MASTER_IDX_W+1)'(N)) begin
                    pos = pos - (MASTER_IDX_W+1)'(N);
                end
            end
        end
        idx_o   = pos[MASTER_IDX_W-1:0];
        grant_o = '0;
        for (int i = 0; i < N; i++) begin
            grant_o[i] = found && (idx_o == MASTER_IDX_W'(i));
        end
    end

endmodule

// File: rtl/cpu_bus_arb.sv
// CPU-bus arbiter/sequencer: one access per MEM_LAT+2 cycles, ack MEM_LAT+1 after grant.
// Requests are held until ack; CPU_BUS_ARB_RR_EN selects round-robin over fixed priority.
module cpu_bus_arb
    import nes_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int DATA_W      = CPU_DATA_W,
    parameter int MEM_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_wr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_err,
    output logic                          mem_en,
    output logic                          mem_wr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_err,
    output logic                          err_valid,
    output logic [ADDR_W-1:0]             err_addr,
    output logic [MASTER_IDX_W-1:0]       err_master,
    input  logic                          err_clr
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    bus_state_e              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [MASTER_IDX_W-1:0] idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    rerr_q, rerr_d;
    logic                    err_valid_q, err_valid_d;
    logic [ADDR_W-1:0]       err_addr_q, err_addr_d;
    logic [MASTER_IDX_W-1:0] err_master_q, err_master_d;

    logic [NUM_MASTERS-1:0]  grant;
    logic [MASTER_IDX_W-1:0] pick_idx;
    logic [MASTER_IDX_W-1:0] rr_ptr;
    logic                    sel_wr;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic                    grant_now;

    assign grant_now = (state_q == IDLE) && (|grant);

`ifdef CPU_BUS_ARB_RR_EN
    localparam bit ROTATE = 1'b1;
    logic [MASTER_IDX_W-1:0] ptr_q, ptr_d;

    // Pointer holds the first index searched next, i.e. last winner + 1.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_now) begin
            ptr_d = (pick_idx == MASTER_IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign rr_ptr = ptr_q;
`else
    localparam bit ROTATE = 1'b0;
    assign rr_ptr = '0;
`endif

    bus_arb_pick #(
        .N      (NUM_MASTERS),
        .ROTATE (ROTATE)
    ) u_pick (
        .req_i   (m_req),
        .ptr_i   (rr_ptr),
        .grant_o (grant),
        .idx_o   (pick_idx)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_idx == MASTER_IDX_W'(i)) begin
                sel_wr    = m_wr[i];
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: begin
                if (grant_now) begin
                    state_d = ACCESS;
                    idx_d   = pick_idx;
                    wr_d    = sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    cnt_d   = LAT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = mem_rdata;
                    rerr_d  = mem_err;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A fresh error beats a simultaneous clear so it is never lost.
    always_comb begin
        err_valid_d  = err_valid_q;
        err_addr_d   = err_addr_q;
        err_master_d = err_master_q;
        if ((state_q == RESP) && rerr_q && (!err_valid_q || err_clr)) begin
            err_valid_d  = 1'b1;
            err_addr_d   = addr_q;
            err_master_d = idx_q;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rerr_q       <= 1'b0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            err_master_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rerr_q       <= rerr_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
            err_master_q <= err_master_d;
        end
    end

    always_comb begin
        mem_en    = (state_q == ACCESS);
        mem_wr    = mem_en && wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        m_rdata   = (state_q == RESP) ? rdata_q : '0;
        m_err     = (state_q == RESP) && rerr_q;
        m_ack     = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_ack[i] = (state_q == RESP) && (idx_q == MASTER_IDX_W'(i));
        end
    end

    assign err_valid  = err_valid_q;
    assign err_addr   = err_addr_q;
    assign err_master = err_master_q;

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Self-checking bench for cpu_bus_arb: directed scenarios plus a randomized
// run against a timeline/priority reference model.
module tb_cpu_bus_arb;

    localparam int N   = 2;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req, m_wr, m_ack;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, mem_wdata, mem_rdata;
    logic            m_err, mem_en, mem_wr, mem_err, err_valid, err_clr;
    logic [AW-1:0]   mem_addr, err_addr;
    logic [2:0]      err_master;

    bit              use_fn;
    logic [DW-1:0]   rd_fixed;
    logic            err_fixed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_data(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign mem_rdata = use_fn ? ref_data(mem_addr) : rd_fixed;
    assign mem_err   = use_fn ? 1'b0 : err_fixed;

    cpu_bus_arb #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_LAT     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req      (m_req),
        .m_wr       (m_wr),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_ack      (m_ack),
        .m_rdata    (m_rdata),
        .m_err      (m_err),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .err_valid  (err_valid),
        .err_addr   (err_addr),
        .err_master (err_master),
        .err_clr    (err_clr)
    );

    // Arbitration rule: first requester found searching upward from start.
    function automatic int model_pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int next_start(input int winner);
`ifdef CPU_BUS_ARB_RR_EN
        return (winner + 1) % N;
`else
        return 0 * winner;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int m, input logic req, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_req[m]             = req;
        m_wr[m]              = wr;
        m_addr[m*AW +: AW]   = a;
        m_wdata[m*DW +: DW]  = d;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    // Runs one access from the grant edge to the ack cycle, gathering bus
    // observations; optionally drops or disturbs master chg_m in cycle 1.
    task automatic run_access(input int chg_m, input bit drop,
                              input logic [AW-1:0] ea, input logic ew, input logic [DW-1:0] ed,
                              output int cyc, output int en_cnt, output int wr_cnt, output int bad,
                              output logic [N-1:0] ack, output logic [DW-1:0] rd,
                              output logic er, output logic en_at_ack);
        bit done;
        done = 0; cyc = -1; en_cnt = 0; wr_cnt = 0; bad = 0;
        ack = '0; rd = '0; er = 1'b0; en_at_ack = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            tick();
            if (m_ack !== '0) begin
                done = 1; cyc = k; ack = m_ack; rd = m_rdata; er = m_err; en_at_ack = mem_en;
            end else begin
                if (mem_en === 1'b1) begin
                    en_cnt++;
                    if (mem_addr !== ea || mem_wr !== ew || (ew && mem_wdata !== ed)) bad++;
                end
                if (mem_wr === 1'b1) wr_cnt++;
                if (k == 1 && chg_m >= 0) begin
                    if (drop) m_req[chg_m] = 1'b0;
                    else begin
                        m_addr[chg_m*AW +: AW]  = ~ea;
                        m_wdata[chg_m*DW +: DW] = ~ed;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({m_ack, mem_en, mem_wr, m_err, err_valid} !== '0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0", {m_ack, mem_en, mem_wr, m_err, err_valid});
        end
        checks++;
        if ({m_rdata, mem_addr, mem_wdata, err_addr, err_master} !== '0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {m_rdata, mem_addr, mem_wdata, err_addr, err_master});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (mem_en !== 1'b0 || m_ack !== '0) begin
            errors++; $display("FAIL reset_idle mem_en=%b ack=%b exp 0", mem_en, m_ack);
        end
    endtask

    task automatic test_single_read();
        int cyc, en, wc, bad; logic [N-1:0] ack; logic [DW-1:0] rd; logic er, ea;
        use_fn = 0; rd_fixed = 8'hA5; err_fixed = 1'b0;
        set_master(1, 1'b1, 1'b0, 16'h8000, 8'h00);
        run_access(-1, 0, 16'h8000, 1'b0, 8'h00, cyc, en, wc, bad, ack, rd, er, ea);
        checks++; if (cyc != LAT + 1) begin errors++; $display("FAIL sr_latency got=%0d exp=%0d", cyc, LAT + 1); end
        checks++; if (en != LAT || bad != 0) begin errors++; $display("FAIL sr_mem_en cycles=%0d bad=%0d exp=%0d/0", en, bad, LAT); end
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL sr_ack got=%b exp=10", ack); end
        checks++; if (rd !== 8'hA5 || er !== 1'b0) begin errors++; $display("FAIL sr_rdata got=%h/%b exp=a5/0", rd, er); end
        checks++; if (ea !== 1'b0) begin errors++; $display("FAIL sr_en_in_resp got=%b exp=0", ea); end
        set_master(1, 1'b0, 1'b0, 16'h8000, 8'h00);
        tick();
        checks++; if (m_ack !== '0 || mem_en !== 1'b0) begin errors++; $display("FAIL sr_after ack=%b en=%b exp 0", m_ack, mem_en); end
    endtask

    task automatic test_write_stable();
        int cyc, en, wc, bad; logic [N-1:0] ack; logic [DW-1:0] rd; logic er, ea;
        set_master(0, 1'b1, 1'b1, 16'h0200, 8'h3C);
        run_access(0, 0, 16'h0200, 1'b1, 8'h3C, cyc, en, wc, bad, ack, rd, er, ea);
        checks++; if (en != LAT || wc != LAT) begin errors++; $display("FAIL wr_strobes en=%0d wr=%0d exp=%0d", en, wc, LAT); end
        checks++; if (bad != 0) begin errors++; $display("FAIL wr_stable bad=%0d exp=0", bad); end
        checks++; if (ack !== 2'b01 || cyc != LAT + 1) begin errors++; $display("FAIL wr_ack got=%b@%0d exp=01@%0d", ack, cyc, LAT + 1); end
        set_master(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        tick();
    endtask

    task automatic test_drop_req();
        int cyc, en, wc, bad, extra; logic [N-1:0] ack; logic [DW-1:0] rd; logic er, ea;
        rd_fixed = 8'h3E;
        set_master(1, 1'b1, 1'b0, 16'h1111, 8'h00);
        run_access(1, 1, 16'h1111, 1'b0, 8'h00, cyc, en, wc, bad, ack, rd, er, ea);
        checks++; if (ack !== 2'b10 || cyc != LAT + 1 || rd !== 8'h3E) begin
            errors++; $display("FAIL drop_ack got=%b@%0d rd=%h exp=10@%0d rd=3e", ack, cyc, rd, LAT + 1);
        end
        extra = 0;
        for (int k = 0; k < 2 * (LAT + 2); k++) begin
            tick();
            if (m_ack !== '0 || mem_en !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL drop_no_repeat got=%0d exp=0", extra); end
    endtask

    task automatic test_contention();
        int ptr, last, nack, w; logic [N-1:0] exp_ack;
        pulse_reset();
        use_fn = 1;
        set_master(0, 1'b1, 1'b0, 16'h0100, 8'h00);
        set_master(1, 1'b1, 1'b0, 16'h0101, 8'h00);
        ptr = 0; last = 0; nack = 0;
        for (int k = 1; k <= 6 * (LAT + 2); k++) begin
            tick();
            if (m_ack !== '0) begin
                w = model_pick(2'b11, ptr);
                ptr = next_start(w);
                exp_ack = '0; exp_ack[w] = 1'b1;
                checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL cont_winner got=%b exp=%b", m_ack, exp_ack); end
                checks++; if (k - last != ((nack == 0) ? LAT + 1 : LAT + 2)) begin
                    errors++; $display("FAIL cont_period got=%0d exp=%0d", k - last, (nack == 0) ? LAT + 1 : LAT + 2);
                end
                last = k; nack++;
            end
        end
        checks++; if (nack != 6) begin errors++; $display("FAIL cont_count got=%0d exp=6", nack); end
        m_req = '0;
        tick(); tick();
    endtask

    task automatic test_errors();
        int cyc, en, wc, bad; logic [N-1:0] ack; logic [DW-1:0] rd; logic er, ea;
        use_fn = 0; rd_fixed = 8'h00; err_fixed = 1'b1;
        set_master(1, 1'b1, 1'b0, 16'h4020, 8'h00);
        run_access(-1, 0, 16'h4020, 1'b0, 8'h00, cyc, en, wc, bad, ack, rd, er, ea);
        checks++; if (ack !== 2'b10 || er !== 1'b1) begin errors++; $display("FAIL err1_resp ack=%b err=%b exp=10/1", ack, er); end
        m_req = '0; tick();
        checks++; if (err_valid !== 1'b1 || err_addr !== 16'h4020 || err_master !== 3'd1) begin
            errors++; $display("FAIL err1_capture got=%b/%h/%0d exp=1/4020/1", err_valid, err_addr, err_master);
        end
        set_master(0, 1'b1, 1'b0, 16'h5000, 8'h00);
        run_access(-1, 0, 16'h5000, 1'b0, 8'h00, cyc, en, wc, bad, ack, rd, er, ea);
        m_req = '0; tick();
        checks++; if (er !== 1'b1 || err_valid !== 1'b1 || err_addr !== 16'h4020 || err_master !== 3'd1) begin
            errors++; $display("FAIL err2_keep got=%b/%b/%h/%0d exp=1/1/4020/1", er, err_valid, err_addr, err_master);
        end
        set_master(0, 1'b1, 1'b0, 16'h6000, 8'h00);
        run_access(-1, 0, 16'h6000, 1'b0, 8'h00, cyc, en, wc, bad, ack, rd, er, ea);
        err_clr = 1'b1; m_req = '0;
        tick();
        err_clr = 1'b0;
        checks++; if (err_valid !== 1'b1 || err_addr !== 16'h6000 || err_master !== 3'd0) begin
            errors++; $display("FAIL err_clr_race got=%b/%h/%0d exp=1/6000/0", err_valid, err_addr, err_master);
        end
        err_fixed = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err_valid); end
    endtask

    task automatic test_reset_mid();
        int cyc, en, wc, bad, spur; logic [N-1:0] ack; logic [DW-1:0] rd; logic er, ea;
        use_fn = 0; rd_fixed = 8'h77; err_fixed = 1'b0;
        set_master(0, 1'b1, 1'b0, 16'h1234, 8'h00);
        tick();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h1234) begin errors++; $display("FAIL rm_access en=%b addr=%h exp=1/1234", mem_en, mem_addr); end
        #2; rst = 1'b0; #1;
        checks++; if ({m_ack, m_rdata, m_err, mem_en, mem_wr, mem_addr, mem_wdata, err_valid, err_addr, err_master} !== '0) begin
            errors++; $display("FAIL rm_outputs got=%h exp=0", {m_ack, m_rdata, m_err, mem_en, mem_wr, mem_addr, mem_wdata, err_valid, err_addr, err_master});
        end
        spur = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (m_ack !== '0 || mem_en !== 1'b0) spur++;
        end
        checks++; if (spur != 0) begin errors++; $display("FAIL rm_no_ack got=%0d exp=0", spur); end
        #2; rst = 1'b1;
        run_access(-1, 0, 16'h1234, 1'b0, 8'h00, cyc, en, wc, bad, ack, rd, er, ea);
        checks++; if (ack !== 2'b01 || cyc != LAT + 1 || rd !== 8'h77 || en != LAT) begin
            errors++; $display("FAIL rm_resume got=%b@%0d rd=%h en=%0d exp=01@%0d rd=77 en=%0d", ack, cyc, rd, en, LAT + 1, LAT);
        end
        m_req = '0; tick();
    endtask

    // Reference timeline: idle -> grant -> LAT access cycles -> ack -> idle.
    task automatic test_random();
        int gap[N];
        int mcnt, w, ptr, nacc;
        logic [N-1:0] rs, oh;
        logic [N*AW-1:0] as_s;
        logic [N-1:0] ws;
        logic [N*DW-1:0] ds;
        logic [AW-1:0] ea; logic ew; logic [DW-1:0] ed;
        pulse_reset();
        use_fn = 1;
        mcnt = 0; w = 0; ptr = 0; nacc = 0; ea = '0; ew = 1'b0; ed = '0;
        for (int m = 0; m < N; m++) gap[m] = $urandom_range(0, 2);
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < N; m++) begin
                if (!m_req[m]) begin
                    if (gap[m] == 0) set_master(m, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
                    else gap[m]--;
                end
            end
            rs = m_req; as_s = m_addr; ws = m_wr; ds = m_wdata;
            tick();
            if (mcnt == 0) begin
                if (rs != '0) begin
                    w = model_pick(rs, ptr);
                    ptr = next_start(w);
                    ea = as_s[w*AW +: AW]; ew = ws[w]; ed = ds[w*DW +: DW];
                    mcnt = 1;
                end
            end else if (mcnt == LAT + 1) mcnt = 0;
            else mcnt++;
            checks++;
            if (mcnt >= 1 && mcnt <= LAT) begin
                if (mem_en !== 1'b1 || mem_addr !== ea || mem_wr !== ew || (ew && mem_wdata !== ed) || m_ack !== '0) begin
                    errors++; $display("FAIL rnd_access cyc=%0d en=%b addr=%h wr=%b ack=%b exp addr=%h wr=%b", c, mem_en, mem_addr, mem_wr, m_ack, ea, ew);
                end
            end else if (mcnt == LAT + 1) begin
                oh = '0; oh[w] = 1'b1;
                if (m_ack !== oh || mem_en !== 1'b0 || (!ew && m_rdata !== ref_data(ea))) begin
                    errors++; $display("FAIL rnd_ack cyc=%0d ack=%b rd=%h exp ack=%b rd=%h", c, m_ack, m_rdata, oh, ref_data(ea));
                end
                nacc++;
                if ($urandom_range(0, 1) == 1) set_master(w, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
                else begin m_req[w] = 1'b0; gap[w] = $urandom_range(0, 2); end
            end else begin
                if (mem_en !== 1'b0 || m_ack !== '0) begin
                    errors++; $display("FAIL rnd_idle cyc=%0d en=%b ack=%b exp 0", c, mem_en, m_ack);
                end
            end
        end
        checks++; if (nacc < 40) begin errors++; $display("FAIL rnd_progress got=%0d exp>=40", nacc); end
        m_req = '0; tick(); tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; m_req = '0; m_wr = '0; m_addr = '0; m_wdata = '0; err_clr = 1'b0;
        use_fn = 0; rd_fixed = '0; err_fixed = 1'b0;
        test_reset();
        test_single_read();
        test_write_stable();
        test_drop_req();
        test_contention();
        test_errors();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
